// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: RAM, screen shadow RAM and keyboard register
// behind one combinational load port, with screen stores posted through a FIFO.
module hack_data_memory #(
    parameter int unsigned RAM_WORDS  = 16384,
    parameter int unsigned SCR_WORDS  = 8192,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic        writeM,
    input  logic [15:0] outM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        scr_wr_valid,
    input  logic        scr_wr_ready,
    output logic [12:0] scr_wr_addr,
    output logic [15:0] scr_wr_data,
    output logic        scr_overflow
);
    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [15:0] ram_q [RAM_WORDS];
    logic [15:0] scr_q [SCR_WORDS];
    logic [28:0] fifo_q [FIFO_DEPTH];

    logic [15:0]   kbd_q, kbd_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic              ram_hit, scr_hit, kbd_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic [12:0]       scr_idx;
    logic              push_req, pop, full, push_ok;
    logic [28:0]       head;

    // Address decode
    always_comb begin
        ram_hit = (addressM[14] == 1'b0) && ({17'b0, addressM} < RAM_WORDS);
        scr_hit = (addressM[14:13] == 2'b10) && ({19'b0, addressM[12:0]} < SCR_WORDS);
        kbd_hit = (addressM == 15'h6000);
        ram_idx = addressM[RAM_AW-1:0];
        scr_idx = addressM[12:0];
    end

    always_comb begin
        inM = '0;
        if (ram_hit) begin
            inM = ram_q[ram_idx];
        end else if (scr_hit) begin
            inM = scr_q[scr_idx];
        end else if (kbd_hit) begin
            inM = kbd_q;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        full     = (cnt_q == FULL_CNT);
        pop      = (cnt_q != '0) && scr_wr_ready;
        push_req = writeM && scr_hit;
        push_ok  = push_req && (!full || pop);
        wptr_d   = wptr_q + PW'(push_ok);
        rptr_d   = rptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q | (push_req & ~push_ok);
        kbd_d    = kbd_valid ? kbd_code : kbd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            kbd_q  <= kbd_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Array contents survive reset; stores during reset still land in RAM/shadow.
    always_ff @(posedge clk) begin
        if (writeM && ram_hit) begin
            ram_q[ram_idx] <= outM;
        end
        if (writeM && scr_hit) begin
            scr_q[scr_idx] <= outM;
        end
        if (push_ok && !reset) begin
            fifo_q[wptr_q] <= {addressM[12:0], outM};
        end
    end

    always_comb begin
        head         = fifo_q[rptr_q];
        scr_wr_valid = (cnt_q != '0);
        scr_wr_addr  = scr_wr_valid ? head[28:16] : '0;
        scr_wr_data  = scr_wr_valid ? head[15:0]  : '0;
        scr_overflow = ovf_q;
    end

endmodule
